// File: rtl/wallace_mul_checker_if.sv
// rtl/wallace_mul_checker_if.sv - transaction and result bundle between the multiplier side and the checker
interface wallace_mul_checker_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   number1;
  logic [WIDTH-1:0]   number0;
  logic [2*WIDTH-1:0] dut_q;
  logic               done;
  logic               match;
  logic [2*WIDTH-1:0] ref_q;
  logic [CNT_W-1:0]   pass_cnt;
  logic [CNT_W-1:0]   err_cnt;
  logic               err_sticky;

  modport master (
    output in_valid, number1, number0, dut_q,
    input  in_ready, done, match, ref_q, pass_cnt, err_cnt, err_sticky
  );

  modport slave (
    input  in_valid, number1, number0, dut_q,
    output in_ready, done, match, ref_q, pass_cnt, err_cnt, err_sticky
  );
endinterface

// File: rtl/wallace_mul_checker.sv
// rtl/wallace_mul_checker.sv - shift-add reference multiplier that checks wallace_mul products and counts results
module wallace_mul_checker #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  wallace_mul_checker_if.slave   bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] q_cap;
  logic [CW-1:0]      bit_cnt;
  logic               done_r;
  logic               match_r;
  logic [2*WIDTH-1:0] ref_r;
  logic [CNT_W-1:0]   pass_r;
  logic [CNT_W-1:0]   err_r;
  logic               sticky_r;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      q_cap    <= '0;
      bit_cnt  <= '0;
      done_r   <= 1'b0;
      match_r  <= 1'b0;
      ref_r    <= '0;
      pass_r   <= '0;
      err_r    <= '0;
      sticky_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            mcand   <= {{WIDTH{1'b0}}, bus.number1};
            mplier  <= bus.number0;
            q_cap   <= bus.dut_q;
            acc     <= '0;
            bit_cnt <= '0;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          // Always WIDTH iterations so latency is independent of the operands.
          if (mplier[0]) acc <= acc + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(WIDTH - 1)) state <= S_CHECK;
        end
        S_CHECK: begin
          ref_r   <= acc;
          match_r <= (acc == q_cap);
          done_r  <= 1'b1;
          if (acc == q_cap) begin
            if (pass_r != '1) pass_r <= pass_r + 1'b1;
          end else begin
            if (err_r != '1) err_r <= err_r + 1'b1;
            sticky_r <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.done       = done_r;
  assign bus.match      = match_r;
  assign bus.ref_q      = ref_r;
  assign bus.pass_cnt   = pass_r;
  assign bus.err_cnt    = err_r;
  assign bus.err_sticky = sticky_r;
endmodule

// File: tb/tb_wallace_mul_checker.sv
// tb/tb_wallace_mul_checker.sv - directed self-checking bench for wallace_mul_checker
module tb_wallace_mul_checker;
  logic sys_clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 sys_clk = ~sys_clk;

  wallace_mul_checker_if #(.WIDTH(16), .CNT_W(16)) bus ();
  wallace_mul_checker_if #(.WIDTH(16), .CNT_W(4))  bus4 ();

  wallace_mul_checker #(.WIDTH(16), .CNT_W(16)) dut (.sys_clk(sys_clk), .rst_n(rst_n), .bus(bus));
  wallace_mul_checker #(.WIDTH(16), .CNT_W(4))  dut4 (.sys_clk(sys_clk), .rst_n(rst_n), .bus(bus4));

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Accepts one transaction and returns the number of edges from accept to the done pulse.
  task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input logic [31:0] q, output int lat);
    int n = 0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    bus.number1 = a; bus.number0 = b; bus.dut_q = q; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.done && lat < 60) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b expected 1", bus.in_ready); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b expected 0", bus.done); end
    tests++; if (bus.match !== 1'b0) begin fails++; $display("FAIL reset_match got %0b expected 0", bus.match); end
    tests++; if (bus.ref_q !== 32'd0) begin fails++; $display("FAIL reset_ref_q got %0d expected 0", bus.ref_q); end
    tests++; if (bus.pass_cnt !== 16'd0) begin fails++; $display("FAIL reset_pass_cnt got %0d expected 0", bus.pass_cnt); end
    tests++; if (bus.err_cnt !== 16'd0) begin fails++; $display("FAIL reset_err_cnt got %0d expected 0", bus.err_cnt); end
    tests++; if (bus.err_sticky !== 1'b0) begin fails++; $display("FAIL reset_err_sticky got %0b expected 0", bus.err_sticky); end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    int lat;
    do_txn(16'd250, 16'd11451, 32'd2862750, lat);
    tests++; if (lat !== 17) begin fails++; $display("FAIL latency_edges got %0d expected 17", lat); end
    tests++; if (bus.match !== 1'b1) begin fails++; $display("FAIL latency_match got %0b expected 1", bus.match); end
    tests++; if (bus.ref_q !== 32'd2862750) begin fails++; $display("FAIL latency_ref_q got %0d expected 2862750", bus.ref_q); end
    tests++; if (bus.pass_cnt !== 16'd1) begin fails++; $display("FAIL latency_pass_cnt got %0d expected 1", bus.pass_cnt); end
    tick();
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL latency_done_width got %0b expected 0", bus.done); end
  endtask

  task automatic test_mismatch();
    int lat;
    do_txn(16'd32000, 16'd11, 32'd352001, lat);
    tests++; if (bus.ref_q !== 32'd352000) begin fails++; $display("FAIL mism_ref_q got %0d expected 352000", bus.ref_q); end
    tests++; if (bus.match !== 1'b0) begin fails++; $display("FAIL mism_match got %0b expected 0", bus.match); end
    tests++; if (bus.err_cnt !== 16'd1) begin fails++; $display("FAIL mism_err_cnt got %0d expected 1", bus.err_cnt); end
    tests++; if (bus.err_sticky !== 1'b1) begin fails++; $display("FAIL mism_sticky got %0b expected 1", bus.err_sticky); end
    do_txn(16'd0, 16'd850, 32'd0, lat);
    tests++; if (bus.match !== 1'b1) begin fails++; $display("FAIL mism_next_match got %0b expected 1", bus.match); end
    tests++; if (bus.err_sticky !== 1'b1) begin fails++; $display("FAIL mism_sticky_hold got %0b expected 1", bus.err_sticky); end
    tests++; if (bus.pass_cnt !== 16'd2) begin fails++; $display("FAIL mism_pass_cnt got %0d expected 2", bus.pass_cnt); end
  endtask

  task automatic test_corners();
    int lat;
    do_txn(16'hFFFF, 16'hFFFF, 32'hFFFE0001, lat);
    tests++; if (bus.ref_q !== 32'hFFFE0001 || bus.match !== 1'b1) begin fails++; $display("FAIL corner_max got ref %0h match %0b expected fffe0001 match 1", bus.ref_q, bus.match); end
    do_txn(16'd0, 16'hFFFF, 32'd0, lat);
    tests++; if (bus.ref_q !== 32'd0 || bus.match !== 1'b1) begin fails++; $display("FAIL corner_zero got ref %0d match %0b expected 0 match 1", bus.ref_q, bus.match); end
    do_txn(16'd1, 16'd40000, 32'd40000, lat);
    tests++; if (bus.ref_q !== 32'd40000 || bus.match !== 1'b1) begin fails++; $display("FAIL corner_one got ref %0d match %0b expected 40000 match 1", bus.ref_q, bus.match); end
    tests++; if (lat !== 17) begin fails++; $display("FAIL corner_latency got %0d expected 17", lat); end
    tests++; if (bus.pass_cnt !== 16'd5) begin fails++; $display("FAIL corner_pass_cnt got %0d expected 5", bus.pass_cnt); end
  endtask

  task automatic test_toggle();
    int n = 0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    bus.number1 = 16'd7; bus.number0 = 16'd9; bus.dut_q = 32'd63; bus.in_valid = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      bus.number1 = 16'($urandom); bus.number0 = 16'($urandom); bus.dut_q = $urandom;
      tick();
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin tick(); n++; end
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL toggle_done got %0b expected 1", bus.done); end
    tests++; if (bus.ref_q !== 32'd63 || bus.match !== 1'b1) begin fails++; $display("FAIL toggle_ref_q got %0d match %0b expected 63 match 1", bus.ref_q, bus.match); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    logic rdy;
    int n = 0;
    bus.number1 = 16'd3; bus.number0 = 16'd5; bus.dut_q = 32'd15; bus.in_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      rdy = bus.in_ready;
      tick();
      if (rdy) acc_cyc.push_back(c);
    end
    bus.in_valid = 1'b0;
    tests++; if (acc_cyc.size() < 4) begin fails++; $display("FAIL b2b_accepts got %0d expected 4", acc_cyc.size()); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      tests++; if (acc_cyc[i] - acc_cyc[i-1] !== 18) begin fails++; $display("FAIL b2b_gap%0d got %0d expected 18", i, acc_cyc[i] - acc_cyc[i-1]); end
    end
    while (!bus.in_ready && n < 40) begin tick(); n++; end
    tick();
  endtask

  task automatic test_mid_reset();
    int lat = 0;
    int n = 0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    bus.number1 = 16'd123; bus.number0 = 16'd45; bus.dut_q = 32'd5535; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready got %0b expected 1", bus.in_ready); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL midrst_done got %0b expected 0", bus.done); end
    tests++; if (bus.pass_cnt !== 16'd0 || bus.err_cnt !== 16'd0) begin fails++; $display("FAIL midrst_counters got %0d/%0d expected 0/0", bus.pass_cnt, bus.err_cnt); end
    tests++; if (bus.err_sticky !== 1'b0) begin fails++; $display("FAIL midrst_sticky got %0b expected 0", bus.err_sticky); end
    rst_n = 1'b1;
    bus.number1 = 16'd100; bus.number0 = 16'd200; bus.dut_q = 32'd20000; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    while (!bus.done && lat < 60) begin tick(); lat++; end
    tests++; if (lat !== 17) begin fails++; $display("FAIL midrst_release_latency got %0d expected 17", lat); end
    tests++; if (bus.ref_q !== 32'd20000 || bus.pass_cnt !== 16'd1) begin fails++; $display("FAIL midrst_release_check got ref %0d pass %0d expected 20000 pass 1", bus.ref_q, bus.pass_cnt); end
  endtask

  task automatic test_saturation();
    int n;
    for (int i = 0; i < 20; i++) begin
      n = 0;
      while (!bus4.in_ready && n < 50) begin tick(); n++; end
      bus4.number1 = 16'd2; bus4.number0 = 16'd2; bus4.dut_q = 32'd5; bus4.in_valid = 1'b1;
      tick();
      bus4.in_valid = 1'b0;
      n = 0;
      while (!bus4.done && n < 60) begin tick(); n++; end
      if (i == 14) begin
        tests++; if (bus4.err_cnt !== 4'd15) begin fails++; $display("FAIL sat_err_at15 got %0d expected 15", bus4.err_cnt); end
      end
    end
    tests++; if (bus4.err_cnt !== 4'd15) begin fails++; $display("FAIL sat_err_cnt got %0d expected 15", bus4.err_cnt); end
    tests++; if (bus4.pass_cnt !== 4'd0) begin fails++; $display("FAIL sat_pass_cnt got %0d expected 0", bus4.pass_cnt); end
    tests++; if (bus4.err_sticky !== 1'b1) begin fails++; $display("FAIL sat_sticky got %0b expected 1", bus4.err_sticky); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;  bus.number1 = '0;  bus.number0 = '0;  bus.dut_q = '0;
    bus4.in_valid = 1'b0; bus4.number1 = '0; bus4.number0 = '0; bus4.dut_q = '0;
    tick();
    test_reset();
    test_latency();
    test_mismatch();
    test_corners();
    test_toggle();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
